// File: rtl/rid_priority_select_pkg.sv
// Shared classification constants: RID geometry used by the merge tree and the
// priority selector, plus the width of the {hit, rid, cnt} result record.
package rid_priority_select_pkg;

  localparam int CLS_RID_WIDTH   = 4;
  localparam int CLS_NUM_RID     = 8;
  localparam int CLS_LOG_NUM_RID = 3;

  localparam int RIDS_WIDTH = CLS_RID_WIDTH * CLS_NUM_RID;

  // Count field needs log2(NUM_RID)+1 bits so a full vector (NUM_RID matches) fits.
  function automatic int result_width(input int rid_w, input int log_num_rid);
    return 1 + rid_w + log_num_rid + 1;
  endfunction

  localparam int RESULT_WIDTH = result_width(CLS_RID_WIDTH, CLS_LOG_NUM_RID);

endpackage

// File: rtl/rid_result_fifo.sv
// First-word-fall-through result buffer with count-based full/empty.
// A push while full is accepted only if the head is popped on the same edge.
module rid_result_fifo #(
  parameter int WIDTH     = 9,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (LOG_DEPTH + 1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;
  assign o_valid = ~w_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
      if (w_wr && !w_pop) begin
        r_count <= r_count + (LOG_DEPTH + 1)'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - (LOG_DEPTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rid_priority_select.sv
// Picks the lowest nonzero RID from a sorted merged vector, counts matches,
// and queues the result behind a one-stage register; drops are flagged sticky.
module rid_priority_select
  import rid_priority_select_pkg::*;
#(
  parameter int RID_WIDTH      = CLS_RID_WIDTH,
  parameter int NUM_RID        = CLS_NUM_RID,
  parameter int log_NUM_RID    = CLS_LOG_NUM_RID,
  parameter int FIFO_DEPTH     = 4,
  parameter int log_FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [0:RID_WIDTH*NUM_RID-1] in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_hit,
  output logic [RID_WIDTH-1:0]         out_rid,
  output logic [log_NUM_RID:0]         out_match_cnt,
  output logic                         overflow
);

  localparam int CntW = log_NUM_RID + 1;
  localparam int ResW = result_width(RID_WIDTH, log_NUM_RID);

  logic                 w_hit;
  logic [RID_WIDTH-1:0] w_rid;
  logic [CntW-1:0]      w_cnt;
  logic [RID_WIDTH-1:0] w_slot;

  logic                 r_s1_valid;
  logic [ResW-1:0]      r_s1_data;
  logic                 r_overflow;

  logic [ResW-1:0]      w_head;
  logic                 w_fifo_valid;
  logic                 w_drop;

  // Scan from the top slot down so the last nonzero seen is the lowest index.
  always_comb begin
    w_hit  = 1'b0;
    w_rid  = '0;
    w_cnt  = '0;
    w_slot = '0;
    for (int i = NUM_RID - 1; i >= 0; i--) begin
      w_slot = in[i*RID_WIDTH +: RID_WIDTH];
      if (w_slot != '0) begin
        w_hit = 1'b1;
        w_rid = w_slot;
        w_cnt = w_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_data <= {w_hit, w_rid, w_cnt};
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  rid_result_fifo #(
    .WIDTH     (ResW),
    .DEPTH     (FIFO_DEPTH),
    .LOG_DEPTH (log_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (r_s1_valid),
    .i_data  (r_s1_data),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_drop  (w_drop)
  );

  assign out_valid = w_fifo_valid;
  assign overflow  = r_overflow;
  // Head storage is not reset, so data outputs are masked to zero when empty.
  assign {out_hit, out_rid, out_match_cnt} = w_fifo_valid ? w_head : '0;

endmodule

// File: doc/rid_priority_select.md
RID_PRIORITY_SELECT -- requirements
Module: rid_priority_select

Interface
REQ-001 SHALL have parameter RID_WIDTH, default 4: bits per rule ID (RID).
REQ-002 SHALL have parameter NUM_RID, default 8: RID slots per merged vector.
REQ-003 SHALL have parameter log_NUM_RID, default 3: log2(NUM_RID).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two.
REQ-005 SHALL have parameter log_FIFO_DEPTH, default 2: log2(FIFO_DEPTH).
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: merged vector present this cycle (latency-matched to the merge tree).
REQ-009 SHALL have port in, input, [0:RID_WIDTH*NUM_RID-1]: merged, ascending-sorted RID vector; slot 0 at bits [0:RID_WIDTH-1].
REQ-010 SHALL have port out_valid, output, 1: result available at FIFO head.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts head result.
REQ-012 SHALL have port out_hit, output, 1: at least one nonzero RID in the vector.
REQ-013 SHALL have port out_rid, output, RID_WIDTH: highest-priority (lowest nonzero) RID, 0 if no hit.
REQ-014 SHALL have port out_match_cnt, output, log_NUM_RID+1: count of nonzero slots.
REQ-015 SHALL have port overflow, output, 1: sticky flag, result dropped.

Function
REQ-016 SHALL treat RID value 0 as an empty slot; nonzero values are matches.
REQ-017 SHALL, when in_valid=1, select out_rid as the nonzero slot with the lowest slot index (lowest value, given sorted input).
REQ-018 SHALL compute out_match_cnt as the number of nonzero slots, range 0..NUM_RID, with no truncation.
REQ-019 SHALL register {hit, rid, cnt} plus a valid bit into a stage-1 register at the edge that samples in_valid=1.
REQ-020 SHALL write the stage-1 result into the FIFO on the following edge: two-edge latency from input to out_valid when the FIFO is empty.
REQ-021 SHALL present out_hit, out_rid and out_match_cnt as first-word-fall-through from the FIFO head; they are valid only while out_valid=1.
REQ-022 SHALL pop the head on any edge with out_valid=1 and out_ready=1.
REQ-023 SHALL hold out_valid and the head data stable while out_ready=0.
REQ-024 SHALL, when full and popping in the same cycle, accept the stage-1 push with no loss.
REQ-025 SHALL, when full and not popping while stage 1 is valid, drop that result, leave the FIFO unchanged and set overflow=1.
REQ-026 SHALL keep overflow at 1 until reset.
REQ-027 SHALL never back-pressure the input, because the upstream merge tree cannot stall.
REQ-028 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-029 SHALL track occupancy with a log_FIFO_DEPTH+1-bit count, so full and empty are distinguished.
REQ-030 SHALL ignore out_ready while the FIFO is empty.

Reset
REQ-031 SHALL, on reset assertion, immediately clear the stage-1 valid bit, pointers, count and overflow, regardless of clk.
REQ-032 SHALL drive out_valid=0, out_hit=0, out_rid=0, out_match_cnt=0 and overflow=0 during reset.
REQ-033 SHALL discard in-flight results when reset asserts mid-operation, with no output after release until a new in_valid.
REQ-034 SHALL ignore in_valid on any edge where reset=1.

Structure
REQ-035 SHALL take RID_WIDTH, NUM_RID and log_NUM_RID from the shared classification package also used by the merge tree.
REQ-036 SHALL place the RIDS_WIDTH = RID_WIDTH*NUM_RID constant and the {hit, rid, cnt} result-record width in that package.
REQ-037 SHALL implement the buffer as one sub-module, rid_result_fifo (parameterised width/depth, FWFT, count-based full/empty); priority-select logic stays in the top.

Verification
REQ-038 SHALL verify: in=32'h00_01_23_45, in_valid for 1 cycle, out_ready=1 -> two edges later out_valid=1, out_hit=1, out_rid=1, out_match_cnt=5.
REQ-039 SHALL verify: in=32'h00_00_00_00 -> out_hit=0, out_rid=0, out_match_cnt=0, out_valid=1.
REQ-040 SHALL verify: in=32'h01_23_45_67 then 32'h00_00_23_79 back-to-back -> results in order, (1,rid=1,cnt=7) then (1,rid=2,cnt=4).
REQ-041 SHALL verify: out_ready=0 with 5 consecutive valid inputs, FIFO_DEPTH=4 -> first 4 retained, 5th dropped, overflow=1, then out_ready=1 drains exactly 4.
REQ-042 SHALL verify: FIFO full, out_ready=1 and a new input arriving on the same edge -> no drop, overflow stays 0, occupancy stays 4.
REQ-043 SHALL verify: reset asserted asynchronously between clk edges with 3 results queued -> out_valid and overflow go to 0 immediately; no result appears after release.
